// File: rtl/skyfi_pkg.sv
// Shared types and constants for the optical-link transmit path.
package skyfi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } tx_state_t;

  localparam int PKT_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  always_comb begin
    int unsigned idx;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/tx_scheduler.sv
// Shares one PPM Encoder between N_REQ packet sources: round-robin grant,
// launch handshake, wait for transmit completion, then a guard gap.
module tx_scheduler
  import skyfi_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int N_PKT  = PKT_W,
  parameter int GAP_CT = 2000,
  parameter int ACK_TO = 16,
  parameter int IW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0][N_PKT-1:0] req_data,
  output logic [N_REQ-1:0]            req_ack,
  output logic [N_PKT-1:0]            enc_data,
  output logic                        enc_valid,
  input  logic                        enc_ready,
  output logic [IW-1:0]               grant_id,
  output logic                        busy,
  output logic                        err_noack,
  output logic [15:0]                 pkt_count
);

  localparam int TW = $clog2(ACK_TO + 1);

  if (GAP_CT == 0) begin : g_bad_gap
    $fatal(1, "tx_scheduler: GAP_CT must be non-zero");
  end

  tx_state_t        state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [N_PKT-1:0] data_q, data_d;
  logic [15:0]      pkt_q, pkt_d;
  logic [15:0]      gap_q, gap_d;
  logic [TW-1:0]    to_q, to_d;
  logic             err_q, err_d;

  logic [IW-1:0]    gnt_idx;
  logic             gnt_any;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    pkt_d   = pkt_q;
    gap_d   = gap_q;
    to_d    = to_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        // enc_ready low here means the Encoder is still sending from before a reset.
        if (gnt_any && enc_ready) begin
          grant_d = gnt_idx;
          data_d  = req_data[gnt_idx];
          ptr_d   = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        pkt_d   = pkt_q + 16'd1;
        to_d    = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!enc_ready) begin
          state_d = WAIT_DONE;
        end else if (to_q == TW'(ACK_TO - 1)) begin
          err_d   = 1'b1;
          gap_d   = 16'(GAP_CT - 1);
          state_d = GAP;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (enc_ready) begin
          gap_d   = 16'(GAP_CT - 1);
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      pkt_q   <= '0;
      gap_q   <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      pkt_q   <= pkt_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    req_ack = '0;
    if (state_q == LAUNCH) req_ack[grant_q] = 1'b1;
  end

  assign enc_valid = (state_q == LAUNCH);
  assign busy      = (state_q != IDLE);
  assign enc_data  = data_q;
  assign grant_id  = grant_q;
  assign err_noack = err_q;
  assign pkt_count = pkt_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler with a scoreboard of expected launches.
module tb_tx_scheduler;

  localparam int N_REQ  = 2;
  localparam int N_PKT  = 8;
  localparam int GAP_CT = 4;
  localparam int ACK_TO = 16;
  localparam int ENC_BUSY = 50;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic [N_REQ-1:0]            req_valid = '0;
  logic [N_REQ-1:0][N_PKT-1:0] req_data = '0;
  logic [N_REQ-1:0]            req_ack;
  logic [N_PKT-1:0]            enc_data;
  logic                        enc_valid;
  logic                        enc_ready;
  logic [0:0]                  grant_id;
  logic                        busy;
  logic                        err_noack;
  logic [15:0]                 pkt_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int          id;
    logic [7:0]  data;
  } exp_t;
  exp_t sb[$];

  logic enc_stuck = 1'b0;
  int   enc_cnt = 0;

  tx_scheduler #(
    .N_REQ(N_REQ), .N_PKT(N_PKT), .GAP_CT(GAP_CT), .ACK_TO(ACK_TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .enc_data(enc_data), .enc_valid(enc_valid),
    .enc_ready(enc_ready), .grant_id(grant_id), .busy(busy),
    .err_noack(err_noack), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Encoder model: ready drops the cycle after a launch and stays low ENC_BUSY cycles.
  always @(posedge clk) begin
    if (enc_valid && !enc_stuck) enc_cnt <= ENC_BUSY;
    else if (enc_cnt != 0)       enc_cnt <= enc_cnt - 1;
  end
  assign enc_ready = (enc_cnt == 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every launch must match the oldest expected grant.
  always @(negedge clk) begin
    if (enc_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_launch", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_grant_id", 32'(grant_id), 32'(e.id));
        chk("sb_enc_data", 32'(enc_data), 32'(e.data));
        chk("sb_req_ack",  32'(req_ack),  32'(2'b01 << e.id));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input int id, input logic [7:0] d);
    exp_t e;
    e.id = id;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_launch(input string tag, input int max, output int at);
    bit seen = 0;
    at = -1;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      if (enc_valid) begin
        seen = 1;
        at = cyc;
      end
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int max);
    bit idle = 0;
    for (int i = 0; i < max && !idle; i++) begin
      tick();
      if (!busy) idle = 1;
    end
    chk(tag, 32'(idle), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_valid"}, 32'(enc_valid), 32'd0);
    chk({tag, "_ack"},   32'(req_ack), 32'd0);
    chk({tag, "_data"},  32'(enc_data), 32'd0);
    chk({tag, "_gid"},   32'(grant_id), 32'd0);
    chk({tag, "_err"},   32'(err_noack), 32'd0);
    chk({tag, "_pkt"},   32'(pkt_count), 32'd0);
  endtask

  initial begin
    int t0, t1, at;
    int launches[4];
    bit bad;

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // 1: single request, one-cycle latency
    req_data[0] = 8'hA5;
    req_valid = 2'b01;
    push(0, 8'hA5);
    tick();
    chk("t1_latency_valid", 32'(enc_valid), 32'd1);
    chk("t1_latency_ack", 32'(req_ack), 32'b01);
    req_valid = '0;
    tick();
    chk("t1_pkt_count", 32'(pkt_count), 32'd1);
    chk("t1_data_held", 32'(enc_data), 32'hA5);
    wait_idle("t1_idle", 200);

    // 2: both requesting from a fresh pointer -> 0,1,0,1 at 57-cycle spacing
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_data[0] = 8'h11;
    req_data[1] = 8'h22;
    push(0, 8'h11); push(1, 8'h22); push(0, 8'h11); push(1, 8'h22);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_launch("t2_launch", 100, at);
      launches[k] = at;
    end
    req_valid = '0;
    for (int k = 1; k < 4; k++)
      chk("t2_spacing", 32'(launches[k] - launches[k-1]), 32'd57);
    wait_idle("t2_idle", 200);

    // 3: Encoder never drops ready -> error after ACK_TO, FSM keeps going
    enc_stuck = 1'b1;
    req_data[0] = 8'h33;
    req_valid = 2'b01;
    push(0, 8'h33);
    wait_launch("t3_launch", 10, at);
    req_valid = '0;
    repeat (ACK_TO) tick();
    chk("t3_err_not_early", 32'(err_noack), 32'd0);
    tick();
    chk("t3_err_set", 32'(err_noack), 32'd1);
    enc_stuck = 1'b0;
    req_data[1] = 8'h44;
    req_valid = 2'b10;
    push(1, 8'h44);
    wait_launch("t3_next_launch", 20, at);
    req_valid = '0;
    chk("t3_err_sticky", 32'(err_noack), 32'd1);

    // 4: reset during WAIT_DONE, then no launch until Encoder is idle
    wait_idle("t3_idle", 200);
    req_data[0] = 8'h55;
    req_valid = 2'b01;
    push(0, 8'h55);
    wait_launch("t4_launch", 10, at);
    req_valid = '0;
    repeat (10) tick();
    chk("t4_busy_before_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("t4_reset");
    rst_n = 1'b1;
    req_data[1] = 8'h66;
    req_valid = 2'b10;
    push(1, 8'h66);
    bad = 0;
    for (int i = 0; i < 100 && !enc_ready; i++) begin
      tick();
      if (enc_valid || busy) bad = 1;
    end
    chk("t4_no_launch_while_enc_busy", 32'(bad), 32'd0);
    wait_launch("t4_launch_after_ready", 5, at);
    req_valid = '0;
    wait_idle("t4_idle", 200);

    // 5: requester 1 withdraws while packet 0 is in flight
    req_data[0] = 8'h77;
    req_data[1] = 8'h88;
    req_valid = 2'b11;
    push(0, 8'h77);
    wait_launch("t5_launch0", 10, t0);
    req_valid[1] = 1'b0;
    req_data[0] = 8'h99;
    push(0, 8'h99);
    wait_launch("t5_launch0_again", 100, t1);
    req_valid = '0;
    chk("t5_spacing", 32'(t1 - t0), 32'd57);
    wait_idle("t5_idle", 200);

    // 6: pkt_count wraps
    force dut.pkt_q = 16'hFFFF;
    tick();
    release dut.pkt_q;
    chk("t6_preload", 32'(pkt_count), 32'hFFFF);
    req_data[1] = 8'hC3;
    req_valid = 2'b10;
    push(1, 8'hC3);
    wait_launch("t6_launch", 10, at);
    req_valid = '0;
    tick();
    chk("t6_wrap", 32'(pkt_count), 32'd0);
    wait_idle("t6_idle", 200);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
